jesd204b_rx_lane_sync: RTL and testbench

Multi-lane JESD204B receive link-synchronisation controller. It sits between the GTY transceiver user-data interface and the user/AXI-S conversion logic. Per lane, it runs the code-group-synchronisation (CGS) state machine on K28.5 comma words. It keeps a SYSREF-aligned LMFC counter, drives the shared active-low `io_nsync` request, and releases lane data once every lane is synchronised.

---
 rtl/jesd204b_rx_lane_sync.sv | 185 ++++++++++++++++++
 tb/tb_jesd204b_rx_lane_sync.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/jesd204b_rx_lane_sync.sv
// rtl/jesd204b_rx_lane_sync.sv - JESD204B RX CGS/LMFC lane synchroniser (optional JESD204B_RX_ERR_STAT_EN error counters)
module jesd204b_rx_lane_sync #(
   parameter int LANES          = 2,
   parameter int FRAME_SIZE     = 1,
   parameter int FMLC_NUM       = 8,
   parameter int SUBCLASS       = 1,
   parameter int CGS_WORDS      = 2,
   parameter int ERR_THRESH     = 4,
   parameter int SYSREF_ONESHOT = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic [32*LANES-1:0]   i_rx_data,
   input  logic [4*LANES-1:0]    i_rx_charisk,
   input  logic [4*LANES-1:0]    i_rx_err,
   input  logic                  i_sysref,
   output logic                  io_nsync,
   output logic [32*LANES-1:0]   o_data,
   output logic                  o_valid,
   output logic [2*LANES-1:0]    o_lane_state,
   output logic                  o_lmfc_pulse,
   output logic                  o_sysref_realign
`ifdef JESD204B_RX_ERR_STAT_EN
   ,
   output logic [16*LANES-1:0]   o_err_cnt
`endif
);

   localparam int MF_CLKS = (FRAME_SIZE * FMLC_NUM) / 4;
   localparam int CW      = (MF_CLKS > 1) ? $clog2(MF_CLKS) : 1;

   typedef enum logic [1:0] {
      CS_INIT  = 2'd0,
      CS_CHECK = 2'd1,
      CS_DATA  = 2'd2
   } cgs_state_t;

   logic [CW-1:0]    lmfc_cnt;
   logic [CW-1:0]    lmfc_inc;
   logic [CW-1:0]    lmfc_next;
   logic             sysref_q;
   logic             sysref_seen;
   logic             sysref_edge;
   logic             sysref_load;
   logic [LANES-1:0] lane_init;
   logic [LANES-1:0] lane_data;
   logic [LANES-1:0] lane_drop;
   logic             nsync_release;

   // LMFC next-count: SYSREF reload takes priority over the natural wrap/increment
   always_comb begin
      lmfc_inc    = (lmfc_cnt == CW'(MF_CLKS - 1)) ? '0 : lmfc_cnt + 1'b1;
      sysref_edge = i_sysref & ~sysref_q;
      sysref_load = sysref_edge && ((SYSREF_ONESHOT == 0) || !sysref_seen);
      lmfc_next   = sysref_load ? '0 : lmfc_inc;
   end

   // LMFC counter, boundary marker and SYSREF phase-move flag
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         lmfc_cnt         <= '0;
         sysref_q         <= 1'b0;
         sysref_seen      <= 1'b0;
         o_lmfc_pulse     <= 1'b0;
         o_sysref_realign <= 1'b0;
      end else begin
         lmfc_cnt         <= lmfc_next;
         sysref_q         <= i_sysref;
         sysref_seen      <= sysref_seen | sysref_edge;
         o_lmfc_pulse     <= (lmfc_next == '0);
         o_sysref_realign <= sysref_edge && (lmfc_inc != '0);
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      cgs_state_t state_q, state_d;
      logic [2:0] cnt_q, cnt_d;
      logic [7:0] errs_q, errs_d;
      logic       is_err;
      logic       is_comma;
      logic       bad;

      assign is_err   = |i_rx_err[4*g +: 4];
      assign is_comma = (i_rx_data[32*g +: 32] == 32'hBCBC_BCBC) &&
                        (&i_rx_charisk[4*g +: 4]) && !is_err;
      // commas after ILAS are as unexpected as disparity errors
      assign bad      = is_err | is_comma;

      // CGS state register
      always_ff @(posedge i_clk) begin
         if (!i_rstn) begin
            state_q <= CS_INIT;
            cnt_q   <= '0;
            errs_q  <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            errs_q  <= errs_d;
         end
      end

      // CGS next-state: comma lock, check-window errors, data-phase error budget
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         errs_d  = errs_q;
         case (state_q)
            CS_INIT: begin
               if (is_comma) begin
                  if (cnt_q + 3'd1 == 3'(CGS_WORDS)) begin
                     state_d = CS_CHECK;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            CS_CHECK: begin
               if (is_err) begin
                  if (cnt_q + 3'd1 == 3'd3) begin
                     state_d = CS_INIT;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end else if (!is_comma && io_nsync) begin
                  state_d = CS_DATA;
                  cnt_d   = '0;
               end
            end
            CS_DATA: begin
               errs_d = o_lmfc_pulse ? {7'd0, bad} : errs_q + {7'd0, bad};
               if (errs_d >= 8'(ERR_THRESH)) begin
                  state_d = CS_INIT;
                  errs_d  = '0;
               end
            end
            default: begin
               state_d = CS_INIT;
               cnt_d   = '0;
               errs_d  = '0;
            end
         endcase
      end

      assign lane_init[g]           = (state_q == CS_INIT);
      assign lane_data[g]           = (state_q == CS_DATA);
      assign lane_drop[g]           = (state_d == CS_INIT) && (state_q != CS_INIT);
      assign o_lane_state[2*g +: 2] = state_q;

`ifdef JESD204B_RX_ERR_STAT_EN
      logic [15:0] err_cnt_q;

      // saturating error-word statistic, independent of CGS state
      always_ff @(posedge i_clk) begin
         if (!i_rstn) begin
            err_cnt_q <= '0;
         end else if (is_err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
         end
      end

      assign o_err_cnt[16*g +: 16] = err_cnt_q;
`endif
   end

   // subclass 1 lines the release up with the LMFC boundary the pulse register marks
   assign nsync_release = (SUBCLASS == 0) ? 1'b1 : (lmfc_next == '0);

   // SYNC~ request, registered lane data and link-valid
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         io_nsync <= 1'b0;
         o_data   <= '0;
         o_valid  <= 1'b0;
      end else begin
         io_nsync <= !(|lane_init) && (io_nsync || (nsync_release && !(|lane_drop)));
         o_data   <= i_rx_data;
         o_valid  <= &lane_data;
      end
   end

endmodule

// File: tb/tb_jesd204b_rx_lane_sync.sv
// tb/tb_jesd204b_rx_lane_sync.sv - directed bench for jesd204b_rx_lane_sync (two configurations)
module tb_jesd204b_rx_lane_sync;

   localparam logic [31:0] COMMA = 32'hBCBC_BCBC;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance A: F=1 K=8 (MF_CLKS=2), subclass 1
   logic        a_rstn, a_sysref;
   logic [63:0] a_data;
   logic [7:0]  a_k, a_e;
   logic        a_nsync, a_valid, a_pulse, a_realign;
   logic [63:0] a_odata;
   logic [3:0]  a_state;
   // instance B: F=4 K=8 (MF_CLKS=8), subclass 0, SYSREF one-shot
   logic        b_rstn, b_sysref;
   logic [63:0] b_data;
   logic [7:0]  b_k, b_e;
   logic        b_nsync, b_valid, b_pulse, b_realign;
   logic [63:0] b_odata;
   logic [3:0]  b_state;
`ifdef JESD204B_RX_ERR_STAT_EN
   logic [31:0] a_errcnt, b_errcnt;
`endif

   int checks = 0;
   int errors = 0;

   jesd204b_rx_lane_sync #(
      .LANES(2), .FRAME_SIZE(1), .FMLC_NUM(8), .SUBCLASS(1),
      .CGS_WORDS(2), .ERR_THRESH(4), .SYSREF_ONESHOT(0)
   ) u_a (
      .i_clk(clk), .i_rstn(a_rstn), .i_rx_data(a_data), .i_rx_charisk(a_k),
      .i_rx_err(a_e), .i_sysref(a_sysref), .io_nsync(a_nsync), .o_data(a_odata),
      .o_valid(a_valid), .o_lane_state(a_state), .o_lmfc_pulse(a_pulse),
      .o_sysref_realign(a_realign)
`ifdef JESD204B_RX_ERR_STAT_EN
      , .o_err_cnt(a_errcnt)
`endif
   );

   jesd204b_rx_lane_sync #(
      .LANES(2), .FRAME_SIZE(4), .FMLC_NUM(8), .SUBCLASS(0),
      .CGS_WORDS(2), .ERR_THRESH(4), .SYSREF_ONESHOT(1)
   ) u_b (
      .i_clk(clk), .i_rstn(b_rstn), .i_rx_data(b_data), .i_rx_charisk(b_k),
      .i_rx_err(b_e), .i_sysref(b_sysref), .io_nsync(b_nsync), .o_data(b_odata),
      .o_valid(b_valid), .o_lane_state(b_state), .o_lmfc_pulse(b_pulse),
      .o_sysref_realign(b_realign)
`ifdef JESD204B_RX_ERR_STAT_EN
      , .o_err_cnt(b_errcnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_rstn = 1'b0; a_sysref = 1'b0; a_data = '0; a_k = '0; a_e = '0;
      b_rstn = 1'b0; b_sysref = 1'b0; b_data = '0; b_k = '0; b_e = '0;
      tick(); tick();
      chk("rst_a_nsync",   a_nsync,   0);
      chk("rst_a_odata",   a_odata,   0);
      chk("rst_a_valid",   a_valid,   0);
      chk("rst_a_state",   a_state,   0);
      chk("rst_a_pulse",   a_pulse,   0);
      chk("rst_a_realign", a_realign, 0);
      chk("rst_b_nsync",   b_nsync,   0);
      chk("rst_b_state",   b_state,   0);
`ifdef JESD204B_RX_ERR_STAT_EN
      chk("rst_a_errcnt",  a_errcnt,  0);
`endif

      // A: commas on both lanes -> CHECK after two words, nsync on LMFC pulse
      a_rstn = 1'b1; a_data = {COMMA, COMMA}; a_k = 8'hFF;
      tick();
      chk("a_e1_state", a_state, 4'h0);
      chk("a_e1_pulse", a_pulse, 0);
      tick();
      chk("a_check_state", a_state, 4'h5);
      chk("a_e2_pulse",    a_pulse, 1);
      chk("a_e2_nsync",    a_nsync, 0);
      tick();
      chk("a_e3_nsync", a_nsync, 0);
      chk("a_e3_pulse", a_pulse, 0);
      tick();
      chk("a_nsync_rise", a_nsync, 1);
      chk("a_e4_pulse",   a_pulse, 1);
      a_data = {32'h5566_7788, 32'h1122_3344}; a_k = 8'h00;
      tick();
      chk("a_data_state", a_state, 4'hA);
      chk("a_e5_valid",   a_valid, 0);
      chk("a_e5_odata",   a_odata, 64'h5566_7788_1122_3344);
      a_data = {32'hDEAD_BEEF, 32'hCAFE_F00D};
      tick();
      chk("a_valid", a_valid, 1);
      chk("a_odata", a_odata, 64'hDEAD_BEEF_CAFE_F00D);

      // A: reset during DATA
      a_rstn = 1'b0;
      tick();
      chk("mrst_nsync",   a_nsync,   0);
      chk("mrst_odata",   a_odata,   0);
      chk("mrst_valid",   a_valid,   0);
      chk("mrst_state",   a_state,   0);
      chk("mrst_pulse",   a_pulse,   0);
      chk("mrst_realign", a_realign, 0);

      // A: lane 1 never sees commas -> nsync held low, lane 0 parks in CHECK
      a_rstn = 1'b1; a_data = {32'h0102_0304, COMMA}; a_k = 8'h0F;
      repeat (6) tick();
      chk("a_l1init_state", a_state, 4'h1);
      chk("a_l1init_nsync", a_nsync, 0);

      // B: subclass 0 release, SYSREF realign and one-shot behaviour
      b_rstn = 1'b1; b_data = {COMMA, COMMA}; b_k = 8'hFF;
      tick(); tick();
      chk("b_check_state", b_state, 4'h5);
      chk("b_f2_nsync",    b_nsync, 0);
      tick();
      chk("b_nsync_rise", b_nsync, 1);
      chk("b_c3_pulse",   b_pulse, 0);
      b_sysref = 1'b1;
      tick();
      chk("b_sr1_realign", b_realign, 1);
      chk("b_sr1_pulse",   b_pulse,   1);
      tick();
      chk("b_sr1_hold_realign", b_realign, 0);
      b_sysref = 1'b0;
      tick();
      b_sysref = 1'b1;
      tick();
      chk("b_sr2_realign", b_realign, 1);
      chk("b_sr2_pulse",   b_pulse,   0);
      b_sysref = 1'b0;

      b_data = {32'h0A0B_0C0D, 32'h0102_0304}; b_k = 8'h00;
      tick();
      chk("b_data_state", b_state, 4'hA);
      chk("b_c4_valid",   b_valid, 0);
      tick();
      chk("b_valid", b_valid, 1);

      // B: five errors straddling an LMFC boundary (3 + 2) never hit the threshold
      b_e = 8'h01;
      repeat (3) tick();
      chk("b_split_pulse", b_pulse, 1);
      repeat (2) tick();
      chk("b_split_state", b_state, 4'hA);
      chk("b_split_valid", b_valid, 1);
      b_e = 8'h00;
      repeat (7) tick();

      // B: four errors inside one multiframe drop lane 0
      b_e = 8'h01;
      repeat (3) tick();
      chk("b_err3_state", b_state, 4'hA);
      tick();
      chk("b_drop_state", b_state, 4'h8);
      chk("b_drop_nsync", b_nsync, 1);
      b_e = 8'h00;
      tick();
      chk("b_drop_nsync_low", b_nsync, 0);
      chk("b_drop_valid",     b_valid, 0);

`ifdef JESD204B_RX_ERR_STAT_EN
      // error statistic counts in any state and saturates
      a_rstn = 1'b0;
      tick();
      chk("es_rst", a_errcnt, 0);
      a_rstn = 1'b1; a_data = '0; a_k = '0; a_e = 8'h01;
      repeat (3) tick();
      chk("es_three", a_errcnt, 32'h0000_0003);
      repeat (65535) tick();
      chk("es_sat", a_errcnt, 32'h0000_FFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
